// File: rtl/pixel_frame_streamer.sv
// pixel_frame_streamer: reads one frame from a linear frame memory and streams
// it as a valid/ready pixel stream with sof/eol/eof markers.
//
// state   | meaning
// IDLE    | waiting for start_i
// STREAM  | issuing memory reads, address 0 .. IMG_W*IMG_H-1
// DRAIN   | all reads issued, emptying the in-flight read and the FIFO
// DONE    | one-cycle done_o pulse, then back to IDLE
module pixel_frame_streamer #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 360,
  parameter int AW    = $clog2(IMG_W*IMG_H)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic          mem_rd_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [7:0]    mem_data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [7:0]    pixel_o,
  output logic          sof_o,
  output logic          eol_o,
  output logic          eof_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [1:0]    state_o
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W*IMG_H-1);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W-1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(IMG_H-1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          inflight_q;
  logic          inf_sof_q, inf_eol_q, inf_eof_q;
  // FIFO entry layout: {pixel[7:0], sof, eol, eof}
  logic [10:0]   fifo_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    cnt_q;

  logic          push, pop, rd_en;
  logic [2:0]    occ_after;
  logic [10:0]   head;
  logic          iss_sof, iss_eol, iss_eof;

  assign head  = fifo_q[rd_ptr_q];
  assign push  = inflight_q;
  assign pop   = (cnt_q != 2'd0) && ready_i;
  // Occupancy is credited with this cycle's pop so that a steady ready_i
  // sustains one read per cycle while the slot count still never exceeds 2.
  assign occ_after = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en = (state_q == S_STREAM) && (occ_after < 3'd2);

  assign iss_sof = (row_q == '0) && (col_q == '0);
  assign iss_eol = (col_q == LAST_COL);
  assign iss_eof = iss_eol && (row_q == LAST_ROW);

  // Next-state logic for the frame sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_STREAM;
      S_STREAM: if (rd_en && (addr_q == LAST_ADDR)) state_d = S_DRAIN;
      S_DRAIN:  if (pop && head[0]) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Read address and column/row position; holds at the last pixel
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else if ((state_q == S_IDLE) && start_i) begin
      addr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else if (rd_en && (addr_q != LAST_ADDR)) begin
      addr_q <= addr_q + AW'(1);
      if (iss_eol) begin
        col_q <= '0;
        row_q <= row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // In-flight read tracking with the flags of the pixel being fetched
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      inf_sof_q  <= 1'b0;
      inf_eol_q  <= 1'b0;
      inf_eof_q  <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      inf_sof_q  <= rd_en && iss_sof;
      inf_eol_q  <= rd_en && iss_eol;
      inf_eof_q  <= rd_en && iss_eof;
    end
  end

  // Two-entry output FIFO
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {mem_data_i, inf_sof_q, inf_eol_q, inf_eof_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign mem_rd_o   = rd_en;
  assign mem_addr_o = addr_q;
  assign valid_o    = (cnt_q != 2'd0);
  assign pixel_o    = valid_o ? head[10:3] : 8'h00;
  assign sof_o      = valid_o && head[2];
  assign eol_o      = valid_o && head[1];
  assign eof_o      = valid_o && head[0];
  assign busy_o     = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign done_o     = (state_q == S_DONE);
  assign state_o    = state_q;

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Testbench for pixel_frame_streamer with a 4x2 frame and memory[a] = a + 8'h10.
module tb_pixel_frame_streamer;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W*H;

  logic       clk = 1'b0;
  logic       rst_i, start_i, ready_i;
  logic       mem_rd_o;
  logic [2:0] mem_addr_o;
  logic [7:0] mem_data_i;
  logic       valid_o;
  logic [7:0] pixel_o;
  logic       sof_o, eol_o, eof_o, busy_o, done_o;
  logic [1:0] state_o;

  pixel_frame_streamer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .valid_o(valid_o), .ready_i(ready_i), .pixel_o(pixel_o),
    .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o),
    .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Frame memory: one-cycle read latency, garbage when not read
  always @(posedge clk)
    mem_data_i <= mem_rd_o ? (8'(mem_addr_o) + 8'h10) : 8'($urandom);

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference stream: the pixel at frame index i and its markers
  function automatic logic [10:0] ref_item(input int i);
    logic [7:0] p;
    p = 8'(i + 16);
    return {p, (i == 0), ((i % W) == W-1), (i == N-1)};
  endfunction

  // Monitor state
  int exp_idx = 0;
  int outstanding = 0;
  int xfer_cnt = 0, sof_cnt = 0, eof_cnt = 0, rd_cnt = 0, done_cnt = 0;
  logic prev_eof = 1'b0;

  always @(negedge clk) begin
    if (rst_i) begin
      exp_idx = 0;
      outstanding = 0;
      prev_eof = 1'b0;
    end else begin
      if (done_o || prev_eof) chk("done_after_eof", 32'(done_o), 32'(prev_eof));
      if (done_o) done_cnt++;
      if (mem_rd_o) rd_cnt++;
      outstanding = outstanding + (mem_rd_o ? 1 : 0) - ((valid_o && ready_i) ? 1 : 0);
      if (mem_rd_o) chk("outstanding_le2", 32'(outstanding <= 2), 32'd1);
      if (valid_o) begin
        chk("stream_item", 32'({pixel_o, sof_o, eol_o, eof_o}), 32'(ref_item(exp_idx)));
        if (ready_i) begin
          xfer_cnt++;
          if (sof_o) sof_cnt++;
          if (eof_o) eof_cnt++;
          exp_idx = (exp_idx + 1) % N;
        end
      end
      prev_eof = valid_o && ready_i && eof_o;
    end
  end

  typedef struct {
    logic       rd;
    logic [2:0] addr;
    logic       valid;
    logic [7:0] pix;
    logic       sof, eol, eof, busy, done;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [19:0] pack_out();
    return {mem_rd_o, mem_rd_o ? mem_addr_o : 3'd0, valid_o,
            valid_o ? pixel_o : 8'd0, valid_o && sof_o, valid_o && eol_o,
            valid_o && eof_o, busy_o, done_o, state_o};
  endfunction

  // Streams one frame. mode 0: ready high, 1: toggling, 2: random,
  // 3: held low for 20 cycles then high. start_i is re-pulsed while busy.
  task automatic run_frame(input int mode);
    int d0;
    bit fin;
    d0 = done_cnt;
    xfer_cnt = 0; sof_cnt = 0; eof_cnt = 0; rd_cnt = 0;
    fin = 0;
    @(posedge clk); #1;
    start_i = 1'b1;
    ready_i = (mode == 3) ? 1'b0 : 1'b1;
    for (int cyc = 1; cyc < 300; cyc++) begin
      @(posedge clk);
      if (done_cnt != d0) begin fin = 1; break; end
      #1;
      start_i = (cyc == 5);
      case (mode)
        0:       ready_i = 1'b1;
        1:       ready_i = cyc[0];
        2:       ready_i = 1'($urandom % 2);
        default: ready_i = (cyc > 20);
      endcase
      if (mode == 3 && cyc == 20) begin
        chk("stall_reads_le2", 32'(rd_cnt <= 2), 32'd1);
        chk("stall_head", 32'({valid_o, pixel_o, sof_o}), {23'd0, 1'b1, 8'h10, 1'b1});
      end
    end
    start_i = 1'b0;
    chk("frame_finished", 32'(fin), 32'd1);
    chk("frame_xfers", 32'(xfer_cnt), 32'(N));
    chk("frame_sof_eof", 32'({sof_cnt[7:0], eof_cnt[7:0]}), 32'h0101);
    chk("frame_dones", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    bit hit;
    rst_i = 1'b1; start_i = 1'b0; ready_i = 1'b1;

    for (int i = 0; i < 12; i++) begin
      int c, idx;
      c = i + 1;
      idx = c - 3;
      tbl[i].rd    = (c <= N);
      tbl[i].addr  = 3'(c - 1);
      tbl[i].valid = (c >= 3) && (c <= N + 2);
      tbl[i].pix   = tbl[i].valid ? 8'(idx + 16) : 8'd0;
      tbl[i].sof   = tbl[i].valid && (idx == 0);
      tbl[i].eol   = tbl[i].valid && ((idx % W) == W-1);
      tbl[i].eof   = tbl[i].valid && (idx == N-1);
      tbl[i].busy  = (c <= N + 2);
      tbl[i].done  = (c == N + 3);
      tbl[i].st    = (c <= N) ? 2'd1 : (c <= N + 2) ? 2'd2 : (c == N + 3) ? 2'd3 : 2'd0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'(pack_out()), 32'd0);
    chk("reset_flags", 32'({pixel_o, sof_o, eol_o, eof_o}), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    repeat (2) @(posedge clk);

    // Minimum-latency frame, cycle by cycle
    #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("latency_cyc%0d", i + 1), 32'(pack_out()),
          32'({tbl[i].rd, tbl[i].rd ? tbl[i].addr : 3'd0, tbl[i].valid, tbl[i].pix,
               tbl[i].sof, tbl[i].eol, tbl[i].eof, tbl[i].busy, tbl[i].done, tbl[i].st}));
    end

    run_frame(1);
    run_frame(3);
    for (int f = 0; f < 4; f++) run_frame(2);

    // Abort after the third transfer
    d0 = done_cnt;
    xfer_cnt = 0;
    hit = 0;
    @(posedge clk); #1;
    start_i = 1'b1; ready_i = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(posedge clk);
      #1 start_i = 1'b0;
      if (xfer_cnt >= 3) begin hit = 1; break; end
    end
    chk("abort_reached_3", 32'(hit), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("abort_outputs_zero", 32'(pack_out()), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    repeat (3) @(posedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_frame(0);

    // Back-to-back frames
    d0 = done_cnt;
    run_frame(0);
    run_frame(0);
    chk("b2b_dones", 32'(done_cnt - d0), 32'd2);

    repeat (3) begin
      @(negedge clk);
      chk("idle_after", 32'({valid_o, busy_o, mem_rd_o, state_o}), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pixel_frame_streamer.md
PIXEL_FRAME_STREAMER -- requirements
Module: pixel_frame_streamer

Interface
REQ-001 SHALL have parameter IMG_W, default 640: pixels per line.
REQ-002 SHALL have parameter IMG_H, default 360: lines per frame (IMG_W*IMG_H = 230400).
REQ-003 SHALL have parameter AW, default $clog2(IMG_W*IMG_H): memory address width.
REQ-004 clk_i  input  1  single clock; all logic on posedge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 start_i  input  1  one-cycle request to stream one frame; ignored unless IDLE.
REQ-007 mem_rd_o  output  1  frame-memory read strobe.
REQ-008 mem_addr_o  output  AW  linear pixel address, row-major from 0.
REQ-009 mem_data_i  input  8  read data, valid exactly 1 cycle after mem_rd_o.
REQ-010 valid_o  output  1  pixel_o and flags valid toward the convolution block's pixel input.
REQ-011 ready_i  input  1  downstream accepts; transfer = valid_o & ready_i.
REQ-012 pixel_o  output  8  pixel value.
REQ-013 sof_o / eol_o / eof_o  output  1 each  first pixel of frame / last of line / last of frame.
REQ-014 busy_o  output  1  high in STREAM or DRAIN.
REQ-015 done_o  output  1  one-cycle pulse after final transfer.
REQ-016 state_o  output  2  FSM state encoding (IDLE=0, STREAM=1, DRAIN=2, DONE=3).

Function
REQ-017 FSM SHALL be: IDLE -start_i-> STREAM; STREAM -last address issued-> DRAIN; DRAIN -last pixel transferred-> DONE; DONE -> IDLE unconditionally next cycle.
REQ-018 Read counter SHALL start at 0 on entering STREAM and increment by 1 per mem_rd_o, never exceeding IMG_W*IMG_H-1.
REQ-019 Output SHALL use a 2-entry FIFO; mem_rd_o asserted only when (FIFO occupancy + in-flight read) < 2, guaranteeing no overflow under any ready_i pattern.
REQ-020 Returned mem_data_i SHALL be written into FIFO the cycle after mem_rd_o, tagged with its column/row flags.
REQ-021 valid_o SHALL equal FIFO non-empty; pixel_o/flags SHALL be the FIFO head and hold stable while valid_o & !ready_i.
REQ-022 Simultaneous FIFO write and read SHALL keep occupancy unchanged and preserve order.
REQ-023 sof_o SHALL be high only with pixel at address 0; eol_o when column = IMG_W-1; eof_o only with address IMG_W*IMG_H-1 (eol_o also high).
REQ-024 Column counter SHALL wrap IMG_W-1 -> 0 and increment row; row SHALL wrap only at end of frame.
REQ-025 Minimum latency: start_i at cycle 0 -> mem_rd_o at cycle 1 -> valid_o at cycle 3 with ready_i held high.
REQ-026 With ready_i held high, throughput SHALL be one pixel per cycle after first pixel.
REQ-027 done_o SHALL pulse exactly once per frame, the cycle after the eof_o transfer; start_i during busy or DONE SHALL be ignored.
REQ-028 Exactly IMG_W*IMG_H transfers SHALL occur per frame, none duplicated or dropped.

Reset
REQ-029 rst_i high SHALL asynchronously force state IDLE, counters 0, FIFO empty, in-flight flag 0.
REQ-030 During reset all outputs SHALL be 0: valid_o, mem_rd_o, mem_addr_o, pixel_o, flags, busy_o, done_o, state_o.
REQ-031 Reset mid-frame SHALL abort the frame; no done_o; next start_i restarts at address 0.

Verification (IMG_W=4, IMG_H=2, memory[a]=a+8'h10)
REQ-032 start_i pulse, ready_i=1 -> pixels 10..17 on 8 consecutive cycles from cycle 3; sof on 10; eol on 13,17; eof on 17; done_o one cycle later.
REQ-033 ready_i toggling 1/0 every cycle -> same 8 values in order, each held while stalled, no extra mem_rd_o beyond 2 outstanding.
REQ-034 ready_i=0 for 20 cycles after start -> at most 2 reads issued, valid_o held with pixel 10; release -> full frame completes.
REQ-035 start_i re-pulsed while busy_o -> ignored; exactly 8 transfers, one done_o.
REQ-036 rst_i asserted after 3rd transfer -> outputs 0 immediately; new start_i -> stream restarts at pixel 10 with sof_o.
REQ-037 Two back-to-back frames (start_i in cycle after done_o-return to IDLE) -> 16 transfers, two sof_o, two eof_o, two done_o.
